// File: rtl/seq_div.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// It uses the same start/valid/busy handshake as the sequential multiplier.
module seq_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         start,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         valid,
  output logic         busy,
  output logic         div_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    q, r, dsr;
  logic [CW-1:0]   cnt;
  logic [N:0]      shifted, t;
  logic [N-1:0]    q_nxt, r_nxt;
  logic            last;

  // A trial subtraction that goes negative restores the shifted partial remainder.
  always_comb begin
    shifted = {r, q[N-1]};
    t       = shifted - {1'b0, dsr};
    r_nxt   = t[N] ? shifted[N-1:0] : t[N-1:0];
    q_nxt   = {q[N-2:0], ~t[N]};
    last    = (cnt == CW'(N-1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      r         <= '0;
      dsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q   <= dividend;
          r   <= '0;
          dsr <= divisor;
          cnt <= '0;
          // A zero divisor skips CALC and reports saturated quotient immediately.
          if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
            div_zero  <= 1'b1;
          end
        end
        CALC: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed table, handshake corners, reset abort,
// random and exhaustive back-to-back operands against an arithmetic reference.
module tb_seq_div;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] dividend, divisor;
  logic         start;
  logic [N-1:0] quotient, remainder;
  logic         valid, busy, div_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  seq_div #(.N(N)) dut (
    .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor), .start(start),
    .quotient(quotient), .remainder(remainder), .valid(valid), .busy(busy),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one divide at the earliest idle cycle and check latency, pulse width and result.
  // With noise set, start stays high with other operands while the unit is busy.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise);
    logic [N-1:0] eq, er;
    int           edz, elat, k;
    if (b == '0) begin
      eq = '1; er = a; edz = 1; elat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 0; elat = N;
    end
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    if (busy) chk("idle_timeout", 1, 0);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    if (noise) begin dividend = 4'd2; divisor = 4'd1; end
    else start = 1'b0;
    chk("busy_after_start", busy, 1);
    k = 0;
    while (!valid && k < N + 3) begin
      @(negedge clk); k++;
      if (noise) begin dividend = N'($urandom); divisor = N'($urandom_range(1, 15)); end
    end
    chk("latency", valid ? k : -1, elat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_zero", div_zero, edz);
    @(negedge clk);
    start = 1'b0;
    chk("valid_one_cycle", valid, 0);
    if (noise) begin
      @(negedge clk);
      chk("ignored_start_busy", busy, 0);
      chk("ignored_start_valid", valid, 0);
      chk("ignored_start_q", quotient, eq);
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
    tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    tbl[2] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    tbl[3] = '{4'd5,  4'd9,  4'd0,  4'd5, 1'b0};
    tbl[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    tbl[5] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
    tbl[6] = '{4'd6,  4'd4,  4'd1,  4'd2, 1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_zero", div_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, 1'b0);
      chk("tbl_q", quotient, tbl[i].q);
      chk("tbl_r", remainder, tbl[i].r);
      chk("tbl_dz", div_zero, tbl[i].dz);
    end

    // Start requests and operand changes while busy must have no effect.
    do_op(4'd13, 4'd3, 1'b1);

    // Reset in the middle of a calculation abandons it.
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_zero", div_zero, 0);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (N + 2) begin @(negedge clk); if (valid) seen++; end
      chk("abort_no_valid", seen, 0);
    end
    do_op(4'd9, 4'd2, 1'b0);

    repeat (40) do_op(N'($urandom), N'($urandom_range(0, 15)), 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(N'(a), N'(b), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
